// File: rtl/reg_write_arbiter.sv
// Writeback arbiter: two FIFO-queued sources (A = ALU, B = load return) share one registered
// register-bank write port, and PENDING flags registers with a write in flight. Define RR_ARB_EN
// to make conflicts round-robin; the default build gives B fixed priority over A.
module reg_write_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG,
  input  logic [31:0] A_DATA,
  output logic        A_READY,
  input  logic        B_VALID,
  input  logic [4:0]  B_REG,
  input  logic [31:0] B_DATA,
  output logic        B_READY,
  output logic        REG_WRITE,
  output logic [4:0]  WRITE_REGISTER,
  output logic [31:0] WRITE_DATA,
  output logic [31:0] PENDING
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int N_SRC = 2;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           mem_q    [N_SRC][FIFO_DEPTH];
  entry_t           mem_d    [N_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [N_SRC];
  logic [PTR_W-1:0] wr_ptr_d [N_SRC];
  logic [PTR_W-1:0] rd_ptr_q [N_SRC];
  logic [PTR_W-1:0] rd_ptr_d [N_SRC];
  logic [CNT_W-1:0] count_q  [N_SRC];
  logic [CNT_W-1:0] count_d  [N_SRC];

  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_register_q, write_register_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] pending;

  entry_t           in_entry  [N_SRC];
  entry_t           head      [N_SRC];
  logic [PTR_W-1:0] slot_off  [N_SRC][FIFO_DEPTH];
  logic [N_SRC-1:0] in_valid;
  logic [N_SRC-1:0] not_empty;
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic             grant_valid;
  src_e             grant_src;
  entry_t           granted;

`ifdef RR_ARB_EN
  src_e rr_q, rr_d;
`endif

  assign in_entry[SRC_A] = '{rd: A_REG, data: A_DATA};
  assign in_entry[SRC_B] = '{rd: B_REG, data: B_DATA};
  assign in_valid        = {B_VALID, A_VALID};

  // Readiness looks only at registered occupancy, so a full queue refuses a push even on a pop edge.
  always_comb begin
    for (int s = 0; s < N_SRC; s++) begin
      not_empty[s] = (count_q[s] != '0);
      full[s]      = (count_q[s] == CNT_W'(FIFO_DEPTH));
      push[s]      = in_valid[s] & ~full[s];
      head[s]      = mem_q[s][rd_ptr_q[s]];
    end
  end

  // NOTE: every signal driven here is given a default before any branch, so no latch is inferred.
  always_comb begin
    grant_valid = |not_empty;
    grant_src   = not_empty[SRC_B] ? SRC_B : SRC_A;
`ifdef RR_ARB_EN
    rr_d = rr_q;
    if (&not_empty) begin
      grant_src = rr_q;
      rr_d      = (rr_q == SRC_A) ? SRC_B : SRC_A;
    end
`endif
    pop = '0;
    if (grant_valid) begin
      pop[grant_src] = 1'b1;
    end
    granted = head[grant_src];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int s = 0; s < N_SRC; s++) begin
      if (push[s]) begin
        mem_d[s][wr_ptr_q[s]] = in_entry[s];
        wr_ptr_d[s]           = wr_ptr_q[s] + PTR_W'(1);
      end
      if (pop[s]) begin
        rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
      end
      count_d[s] = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
    end
  end

  // A popped r0 entry still updates the address/data stage but never raises the strobe.
  always_comb begin
    reg_write_d      = grant_valid & (granted.rd != 5'd0);
    write_register_d = grant_valid ? granted.rd   : write_register_q;
    write_data_d     = grant_valid ? granted.data : write_data_q;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending = '0;
    for (int s = 0; s < N_SRC; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        slot_off[s][i] = PTR_W'(i) - rd_ptr_q[s];
        if ({1'b0, slot_off[s][i]} < count_q[s]) begin
          pending = pending | (32'd1 << mem_q[s][i].rd);
        end
      end
    end
    if (reg_write_q) begin
      pending = pending | (32'd1 << write_register_q);
    end
    pending[0] = 1'b0;
  end

  // NOTE: queue storage is left unreset; occupancy counters alone decide which slots are live.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < N_SRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

`ifdef RR_ARB_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q <= SRC_A;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign A_READY        = ~full[SRC_A];
  assign B_READY        = ~full[SRC_B];
  assign REG_WRITE      = reg_write_q;
  assign WRITE_REGISTER = write_register_q;
  assign WRITE_DATA     = write_data_q;
  assign PENDING        = pending;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed pushes queue expected writes, and a monitor
// compares every REG_WRITE cycle against the queue head. Expected order follows RR_ARB_EN.
module tb_reg_write_arbiter;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        A_VALID, B_VALID;
  logic [4:0]  A_REG, B_REG;
  logic [31:0] A_DATA, B_DATA;
  logic        A_READY, B_READY;
  logic        REG_WRITE;
  logic [4:0]  WRITE_REGISTER;
  logic [31:0] WRITE_DATA;
  logic [31:0] PENDING;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  reg_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(B_READY),
    .REG_WRITE(REG_WRITE), .WRITE_REGISTER(WRITE_REGISTER),
    .WRITE_DATA(WRITE_DATA), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // Monitor: every strobed write must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && REG_WRITE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write (t=%0t)",
                 WRITE_REGISTER, WRITE_DATA, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_reg", 32'(WRITE_REGISTER), 32'(mon_e.rd));
        check("write_data", WRITE_DATA, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N   = 1'b0;
    A_VALID = 1'b0; A_REG = '0; A_DATA = '0;
    B_VALID = 1'b0; B_REG = '0; B_DATA = '0;
    #12;
    check("rst_a_ready", 32'(A_READY), 1);
    check("rst_b_ready", 32'(B_READY), 1);
    check("rst_reg_write", 32'(REG_WRITE), 0);
    check("rst_write_reg", 32'(WRITE_REGISTER), 0);
    check("rst_write_data", WRITE_DATA, 0);
    check("rst_pending", PENDING, 0);
    RST_N = 1'b1;
    tick();

    // Single A write: two-edge latency, PENDING[5] covers queue and output stage.
    A_VALID = 1'b1; A_REG = 5'd5; A_DATA = 32'h1234;
    expect_write(5'd5, 32'h1234);
    tick();
    A_VALID = 1'b0;
    check("t1_pend_push", PENDING, 32'h20);
    check("t1_no_write_yet", 32'(REG_WRITE), 0);
    tick();
    check("t1_write", 32'(REG_WRITE), 1);
    check("t1_pend_out", PENDING, 32'h20);
    tick();
    check("t1_write_done", 32'(REG_WRITE), 0);
    check("t1_pend_clear", PENDING, 0);
    check("t1_hold_reg", 32'(WRITE_REGISTER), 5);
    check("t1_hold_data", WRITE_DATA, 32'h1234);

    // Simultaneous A/B push: conflict resolution order.
    A_VALID = 1'b1; A_REG = 5'd3; A_DATA = 32'hA;
    B_VALID = 1'b1; B_REG = 5'd4; B_DATA = 32'hB;
`ifdef RR_ARB_EN
    expect_write(5'd3, 32'hA);
    expect_write(5'd4, 32'hB);
`else
    expect_write(5'd4, 32'hB);
    expect_write(5'd3, 32'hA);
`endif
    tick();
    A_VALID = 1'b0; B_VALID = 1'b0;
    check("t2_pend_push", PENDING, 32'h18);
    tick();
    check("t2_pend_first", PENDING, 32'h18);
    tick();
`ifdef RR_ARB_EN
    check("t2_pend_second", PENDING, 32'h10);
`else
    check("t2_pend_second", PENDING, 32'h08);
`endif
    tick();
    check("t2_pend_clear", PENDING, 0);

`ifndef RR_ARB_EN
    // B stays non-empty: A fills to DEPTH, stalls, and only drains after B.
    for (int c = 0; c < DEPTH + 4; c++) begin
      B_VALID = 1'b1; B_REG = 5'd10; B_DATA = 32'hB00 + 32'(c);
      expect_write(5'd10, 32'hB00 + 32'(c));
      A_VALID = (c < DEPTH + 2); A_REG = 5'd11; A_DATA = 32'hA00 + 32'(c);
      tick();
      check("t3_a_ready", 32'(A_READY), 32'(c + 1 < DEPTH));
      check("t3_b_ready", 32'(B_READY), 1);
    end
    A_VALID = 1'b0; B_VALID = 1'b0;
    for (int c = 0; c < DEPTH; c++) expect_write(5'd11, 32'hA00 + 32'(c));
    repeat (DEPTH + 2) tick();
    check("t3_a_ready_drained", 32'(A_READY), 1);
    check("t3_pend_clear", PENDING, 0);
`endif

    // r0 writes are consumed silently.
    A_VALID = 1'b1; A_REG = 5'd0; A_DATA = 32'hFFFF_FFFF;
    tick();
    A_VALID = 1'b0;
    check("t4_a_ready", 32'(A_READY), 1);
    check("t4_pend_queued", PENDING, 0);
    tick();
    check("t4_no_write", 32'(REG_WRITE), 0);
    check("t4_pend_out", PENDING, 0);
    tick();
    check("t4_idle", 32'(REG_WRITE), 0);

    // Three entries in flight, then an asynchronous reset pulse between edges.
    A_VALID = 1'b1; A_REG = 5'd1; A_DATA = 32'h111;
    B_VALID = 1'b1; B_REG = 5'd2; B_DATA = 32'h222;
    tick();
    B_VALID = 1'b0; A_REG = 5'd6; A_DATA = 32'h666;
    tick();
    A_VALID = 1'b0;
    check("t5_pend_before", PENDING, 32'h46);
    #1 RST_N = 1'b0;
    #1;
    check("t5_rst_reg_write", 32'(REG_WRITE), 0);
    check("t5_rst_write_reg", 32'(WRITE_REGISTER), 0);
    check("t5_rst_write_data", WRITE_DATA, 0);
    check("t5_rst_pending", PENDING, 0);
    check("t5_rst_a_ready", 32'(A_READY), 1);
    check("t5_rst_b_ready", 32'(B_READY), 1);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_quiet_write", 32'(REG_WRITE), 0);
      check("t5_quiet_pend", PENDING, 0);
    end

    // Both sources target r7: PENDING[7] holds until the second write retires.
    A_VALID = 1'b1; A_REG = 5'd7; A_DATA = 32'h77A;
    B_VALID = 1'b1; B_REG = 5'd7; B_DATA = 32'h77B;
`ifdef RR_ARB_EN
    expect_write(5'd7, 32'h77A);
    expect_write(5'd7, 32'h77B);
`else
    expect_write(5'd7, 32'h77B);
    expect_write(5'd7, 32'h77A);
`endif
    tick();
    A_VALID = 1'b0; B_VALID = 1'b0;
    check("t6_pend_push", PENDING, 32'h80);
    tick();
    check("t6_pend_first", PENDING, 32'h80);
    check("t6_write_first", 32'(REG_WRITE), 1);
    tick();
    check("t6_pend_second", PENDING, 32'h80);
    check("t6_write_second", 32'(REG_WRITE), 1);
    tick();
    check("t6_pend_clear", PENDING, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
